// File: rtl/filter_result_drain.sv
// filter_result_drain
//   Frame buffer between the contrast filter and the motion-correction stage.
//   One frame of filter results is written by address through the filbuf_*
//   port (FILL), then streamed out in address order on an AXI4-Stream master
//   (DRAIN). After the last beat the block returns to FILL for the next frame.
//
// Ports
//   s_axi_aclk      clock, all logic on the rising edge
//   s_axi_aresetn   asynchronous active-low reset
//   cfg_frame_len   words per frame (0 or > 2**ADDR_W means 2**ADDR_W),
//                   latched at reset release and on every return to FILL
//   filbuf_wready   1 while in FILL and writes are accepted
//   filbuf_wren     write strobe, one word per cycle
//   filbuf_wraddr   write address
//   filbuf_wrdata   write data
//   m_axis_tvalid   stream beat valid
//   m_axis_tready   downstream ready
//   m_axis_tdata    buffer word, addresses 0..len-1 in order
//   m_axis_tlast    marks beat len-1
//   drain_done      one-cycle pulse after the tlast handshake
//   overrun_err     sticky flag, set by a write while filbuf_wready is 0
//   frame_checksum  wrapping sum of the last drained frame (0 when disabled)
//
// Build option
//   FILBUF_CHECKSUM_EN  when defined, accumulates the per-frame checksum;
//                       otherwise frame_checksum is tied to 0.

module filter_result_drain #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [ADDR_W:0]   cfg_frame_len,
  output logic              filbuf_wready,
  input  logic              filbuf_wren,
  input  logic [ADDR_W-1:0] filbuf_wraddr,
  input  logic [DATA_W-1:0] filbuf_wrdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              drain_done,
  output logic              overrun_err,
  output logic [DATA_W-1:0] frame_checksum
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state;
  logic              wready_q;
  logic              init_pend;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   norm_len;
  logic [ADDR_W:0]   last_idx;
  logic [ADDR_W:0]   wcnt;
  logic [ADDR_W:0]   rptr;
  logic              drain_done_q;
  logic              overrun_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              inflight;

  logic [DATA_W-1:0] skid_data [2];
  logic [1:0]        skid_last;
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        occ;
  logic [2:0]        pend_lvl;

  logic              wr_accept;
  logic              enter_drain;
  logic              pop;
  logic              pop_last;
  logic              room;
  logic              issue;

  // Out-of-range or zero lengths select the full buffer depth.
  always_comb begin
    norm_len = cfg_frame_len;
    if ((cfg_frame_len == '0) || (cfg_frame_len > DEPTH_LEN)) begin
      norm_len = DEPTH_LEN;
    end
  end

  assign last_idx    = len - ONE;
  assign wr_accept   = filbuf_wren && wready_q;
  assign enter_drain = (state == ST_FILL) && wr_accept && ((wcnt + ONE) == len);

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = skid_data[rd_sel];
  assign m_axis_tlast  = m_axis_tvalid && skid_last[rd_sel];

  assign pop      = m_axis_tvalid && m_axis_tready;
  assign pop_last = pop && m_axis_tlast;

  // A read is issued only if its data is guaranteed a skid slot when it
  // lands next cycle: entries held plus the read already in flight, minus
  // the beat leaving this cycle, must stay below two. This keeps the skid
  // from overflowing while still sustaining one beat per cycle.
  assign pend_lvl = {1'b0, occ} + {2'b00, inflight};
  assign room     = (pend_lvl < 3'd2) || ((pend_lvl == 3'd2) && pop);
  assign issue    = (state == ST_DRAIN) && (rptr != len) && room;

  // Simple dual-port RAM with a registered read port; no reset so it maps
  // onto block RAM.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_accept) begin
      mem[filbuf_wraddr] <= filbuf_wrdata;
    end
    if (issue) begin
      rd_data <= mem[rptr[ADDR_W-1:0]];
    end
  end

  // Phase control. wready is held low through reset and for the first edge
  // after release, which is where the frame length is first captured.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state        <= ST_FILL;
      wready_q     <= 1'b0;
      init_pend    <= 1'b1;
      len          <= DEPTH_LEN;
      wcnt         <= '0;
      rptr         <= '0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      inflight     <= 1'b0;
      rd_last      <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      inflight     <= issue;
      rd_last      <= issue && (rptr == last_idx);

      if (filbuf_wren && !wready_q) begin
        overrun_q <= 1'b1;
      end

      if (init_pend) begin
        init_pend <= 1'b0;
        len       <= norm_len;
        wready_q  <= 1'b1;
      end

      case (state)
        ST_FILL: begin
          if (wr_accept) begin
            wcnt <= wcnt + ONE;
            if (enter_drain) begin
              wready_q <= 1'b0;
              rptr     <= '0;
              state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (issue) begin
            rptr <= rptr + ONE;
          end
          // rptr only returns to 0 here, so a full-depth frame never wraps.
          if (pop_last) begin
            state        <= ST_FILL;
            wcnt         <= '0;
            rptr         <= '0;
            len          <= norm_len;
            wready_q     <= 1'b1;
            drain_done_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  // Two-entry output skid fed by RAM read data. The head entry drives the
  // stream and only advances on a handshake, so tdata/tlast stay put during
  // back-pressure.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      skid_data[0] <= '0;
      skid_data[1] <= '0;
      skid_last    <= 2'b00;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      occ          <= 2'd0;
    end else begin
      if (inflight) begin
        skid_data[wr_sel] <= rd_data;
        skid_last[wr_sel] <= rd_last;
        wr_sel            <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign filbuf_wready = wready_q;
  assign drain_done    = drain_done_q;
  assign overrun_err   = overrun_q;

`ifdef FILBUF_CHECKSUM_EN
  logic [DATA_W-1:0] sum_acc;
  logic [DATA_W-1:0] checksum_q;

  // The published value includes the tlast beat itself, so it is formed
  // from the running sum plus the current tdata on the final handshake.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sum_acc    <= '0;
      checksum_q <= '0;
    end else begin
      if (enter_drain) begin
        sum_acc <= '0;
      end else if (pop) begin
        sum_acc <= sum_acc + m_axis_tdata;
      end
      if (pop_last) begin
        checksum_q <= sum_acc + m_axis_tdata;
      end
    end
  end

  assign frame_checksum = checksum_q;
`else
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_filter_result_drain.sv
// tb_filter_result_drain
//   Directed bench for filter_result_drain: frames of several lengths, write
//   ordering, back-pressure, blocked writes, full-depth frame and reset abort.

module tb_filter_result_drain;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef FILBUF_CHECKSUM_EN
  localparam logic [31:0] EXP_FULL_SUM = 32'h07FF_E000;
`else
  localparam logic [31:0] EXP_FULL_SUM = 32'h0000_0000;
`endif

  logic              clk;
  logic              rst_n;
  logic [ADDR_W:0]   cfg_frame_len;
  logic              filbuf_wready;
  logic              filbuf_wren;
  logic [ADDR_W-1:0] filbuf_wraddr;
  logic [DATA_W-1:0] filbuf_wrdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              drain_done;
  logic              overrun_err;
  logic [DATA_W-1:0] frame_checksum;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_mem [DEPTH];

  filter_result_drain #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .cfg_frame_len (cfg_frame_len),
    .filbuf_wready (filbuf_wready),
    .filbuf_wren   (filbuf_wren),
    .filbuf_wraddr (filbuf_wraddr),
    .filbuf_wrdata (filbuf_wrdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .drain_done    (drain_done),
    .overrun_err   (overrun_err),
    .frame_checksum(frame_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge and are sampled by the next rising edge.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    @(negedge clk);
    filbuf_wren   = wr;
    filbuf_wraddr = addr;
    filbuf_wrdata = data;
  endtask

  task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    applyStimulus(1'b1, addr, data);
    exp_mem[addr] = data;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, '0);
  endtask

  // Samples the stream once per cycle. mode 0 holds tready high; mode 1
  // drives tready with the repeating pattern 1,0,0,1. Index 0 is the first
  // falling edge after the call.
  task automatic collectStream(input string tag, input int n, input int frame_len,
                               input int mode, output int first_idx, output int last_idx);
    int   beats      = 0;
    int   cyc        = 0;
    int   bad_data   = 0;
    int   bad_last   = 0;
    int   bad_stable = 0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic exp_last;
    first_idx = -1;
    last_idx  = -1;
    while ((beats < n) && (cyc < n * 4 + 40)) begin
      @(negedge clk);
      if (mode == 0) m_axis_tready = 1'b1;
      else m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      if (prev_stall && ((m_axis_tvalid !== 1'b1) || (m_axis_tdata !== prev_data) ||
                         (m_axis_tlast !== prev_last))) begin
        bad_stable++;
      end
      if ((m_axis_tvalid === 1'b1) && (first_idx < 0)) first_idx = cyc;
      if ((m_axis_tvalid === 1'b1) && m_axis_tready) begin
        exp_last = (beats == frame_len - 1);
        if (m_axis_tdata !== exp_mem[beats]) begin
          if (bad_data < 4)
            $display("[TB] %s beat %0d data 0x%08h want 0x%08h", tag, beats,
                     m_axis_tdata, exp_mem[beats]);
          bad_data++;
        end
        if (m_axis_tlast !== exp_last) bad_last++;
        last_idx = cyc;
        beats++;
      end
      prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      cyc++;
    end
    checkOutput({tag, "_beat_count"}, 32'(beats), 32'(n));
    checkOutput({tag, "_bad_data"}, 32'(bad_data), 32'd0);
    checkOutput({tag, "_bad_tlast"}, 32'(bad_last), 32'd0);
    checkOutput({tag, "_unstable_stall"}, 32'(bad_stable), 32'd0);
  endtask

  // The tlast handshake happens on the edge after collectStream returns.
  task automatic checkDone(input string tag);
    @(negedge clk);
    m_axis_tready = 1'b0;
    #1;
    checkOutput({tag, "_drain_done"}, 32'(drain_done), 32'd1);
    checkOutput({tag, "_wready_back"}, 32'(filbuf_wready), 32'd1);
    checkOutput({tag, "_tvalid_idle"}, 32'(m_axis_tvalid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_drain_done_pulse"}, 32'(drain_done), 32'd0);
  endtask

  initial begin
    int first_idx;
    int last_idx;
    int stray;

    rst_n         = 1'b0;
    cfg_frame_len = 15'd4;
    filbuf_wren   = 1'b0;
    filbuf_wraddr = '0;
    filbuf_wrdata = '0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_wready", 32'(filbuf_wready), 32'd0);
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_drain_done", 32'(drain_done), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_err), 32'd0);
    checkOutput("rst_checksum", frame_checksum, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_wready_low", 32'(filbuf_wready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("release_wready_high", 32'(filbuf_wready), 32'd1);

    // Frame 1: len 4, in-order writes, tready held high.
    $display("[TB] frame 1: len 4 in order");
    for (int i = 0; i < 4; i++) writeWord(14'(i), 32'h10 + 32'(i));
    #1;
    checkOutput("f1_wready_before_last", 32'(filbuf_wready), 32'd1);
    idleInputs();
    #1;
    checkOutput("f1_wready_fell", 32'(filbuf_wready), 32'd0);
    collectStream("f1", 4, 4, 0, first_idx, last_idx);
    checkOutput("f1_first_valid_latency_ok",
                32'((first_idx >= 0) && (first_idx + 1 <= 3)), 32'd1);
    checkOutput("f1_no_bubbles", 32'(last_idx - first_idx), 32'd3);
    checkDone("f1");

    // Frame 2: reverse write order plus a blocked write during DRAIN.
    $display("[TB] frame 2: reverse order, blocked write");
    writeWord(14'd3, 32'hA3);
    writeWord(14'd2, 32'hA2);
    writeWord(14'd1, 32'hA1);
    writeWord(14'd0, 32'hA0);
    #1;
    checkOutput("f2_overrun_clear", 32'(overrun_err), 32'd0);
    applyStimulus(1'b1, 14'd0, 32'hDEAD);
    idleInputs();
    #1;
    checkOutput("f2_overrun_set", 32'(overrun_err), 32'd1);
    cfg_frame_len = 15'd8;
    collectStream("f2", 4, 4, 0, first_idx, last_idx);
    checkDone("f2");
    checkOutput("f2_overrun_sticky", 32'(overrun_err), 32'd1);

    // Frame 3: len 8 with tready toggling 1,0,0,1.
    $display("[TB] frame 3: len 8 with back-pressure");
    for (int i = 0; i < 8; i++) writeWord(14'(i), 32'hC0DE_0000 + 32'(i * 32'h111));
    idleInputs();
    cfg_frame_len = 15'd1;
    collectStream("f3", 8, 8, 1, first_idx, last_idx);
    checkDone("f3");

    // Frame 4: single-word frame.
    $display("[TB] frame 4: len 1");
    writeWord(14'd0, 32'h55AA_1234);
    idleInputs();
    #1;
    checkOutput("f4_wready_fell", 32'(filbuf_wready), 32'd0);
    cfg_frame_len = 15'd0;
    collectStream("f4", 1, 1, 0, first_idx, last_idx);
    checkDone("f4");

    // Frame 5: cfg 0 selects full depth, data equals address.
    $display("[TB] frame 5: full depth");
    for (int i = 0; i < DEPTH; i++) writeWord(14'(i), 32'(i));
    idleInputs();
    #1;
    checkOutput("f5_wready_fell", 32'(filbuf_wready), 32'd0);
    cfg_frame_len = 15'd8;
    collectStream("f5", DEPTH, DEPTH, 0, first_idx, last_idx);
    checkOutput("f5_no_bubbles", 32'(last_idx - first_idx), 32'(DEPTH - 1));
    checkDone("f5");
    checkOutput("f5_checksum", frame_checksum, EXP_FULL_SUM);

    // Frame 6: reset after 3 of 8 beats.
    $display("[TB] frame 6: reset mid-drain");
    for (int i = 0; i < 8; i++) writeWord(14'(i), 32'h6000 + 32'(i));
    idleInputs();
    collectStream("f6", 3, 8, 0, first_idx, last_idx);
    @(negedge clk);
    m_axis_tready = 1'b0;
    #1;
    checkOutput("f6_valid_before_reset", 32'(m_axis_tvalid), 32'd1);
    cfg_frame_len = 15'd2;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("f6_tvalid_async_drop", 32'(m_axis_tvalid), 32'd0);
    checkOutput("f6_overrun_reset", 32'(overrun_err), 32'd0);
    checkOutput("f6_wready_in_reset", 32'(filbuf_wready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    stray = 0;
    @(negedge clk);
    #1;
    checkOutput("f6_wready_after_release", 32'(filbuf_wready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      #1;
      if (m_axis_tvalid !== 1'b0) stray++;
    end
    checkOutput("f6_no_stray_beats", 32'(stray), 32'd0);
    m_axis_tready = 1'b0;

    // Frame 7: len 2 latched at release; wcnt restarted from zero.
    $display("[TB] frame 7: len 2 after reset");
    writeWord(14'd0, 32'h71);
    #1;
    checkOutput("f7_wready_after_first", 32'(filbuf_wready), 32'd1);
    writeWord(14'd1, 32'h72);
    idleInputs();
    #1;
    checkOutput("f7_wready_fell", 32'(filbuf_wready), 32'd0);
    collectStream("f7", 2, 2, 0, first_idx, last_idx);
    checkDone("f7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
